// File: rtl/message_printer_ctrl.sv
// UART command responder: 'h' + 4 payload bytes -> ASCII hex report on TX, result on LEDs.
// Optional popcount report/LED display enabled by defining MESSAGE_PRINTER_POPCOUNT_EN.
module message_printer_ctrl (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [7:0] ledout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

`ifdef MESSAGE_PRINTER_POPCOUNT_EN
  localparam logic [3:0] MSG_LEN = 4'd13;
`else
  localparam logic [3:0] MSG_LEN = 4'd10;
`endif

  localparam logic [7:0] CMD_H = 8'h68;

  // Declaration initialisers give the same power-up state as reset.
  state_t      r_state   = S_IDLE;
  logic [1:0]  r_cnt     = 2'd0;
  logic [31:0] r_word    = 32'h0000_0000;
  logic [3:0]  r_idx     = 4'd0;
  logic [7:0]  r_tx_data = 8'h00;
  logic        r_new_tx  = 1'b0;
  logic [7:0]  r_led     = 8'h00;
`ifdef MESSAGE_PRINTER_POPCOUNT_EN
  logic [5:0]  r_pop     = 6'd0;
  logic [5:0]  w_pop_next;
`endif

  state_t      w_next_state;
  logic        w_clear;
  logic        w_shift;
  logic        w_capture;
  logic        w_send;
  logic [31:0] w_word_next;
  logic [7:0]  w_msg_byte;

  function automatic logic [7:0] f_hex(input logic [3:0] nib);
    logic [7:0] v;
    v = {4'h0, nib};
    if (nib < 4'd10) begin
      f_hex = 8'h30 + v;
    end else begin
      f_hex = 8'h37 + v;
    end
  endfunction

`ifdef MESSAGE_PRINTER_POPCOUNT_EN
  function automatic logic [5:0] f_popcount(input logic [31:0] w);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, w[i]};
    end
    f_popcount = c;
  endfunction

  assign w_pop_next = f_popcount(w_word_next);
`endif

  assign w_word_next = {r_word[23:0], rx_data};

  // Next-state and datapath control decode.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_capture    = 1'b0;
    w_send       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (new_rx_data && (rx_data == CMD_H)) begin
          w_clear      = 1'b1;
          w_next_state = S_RECV;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RECV: begin
        if (new_rx_data) begin
          w_shift = 1'b1;
          if (r_cnt == 2'd3) begin
            w_capture    = 1'b1;
            w_next_state = S_SEND;
          end else begin
            w_next_state = S_RECV;
          end
        end else begin
          w_next_state = S_RECV;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          w_send       = 1'b1;
          w_next_state = S_GAP;
        end else begin
          w_next_state = S_SEND;
        end
      end
      S_GAP: begin
        if (r_idx == MSG_LEN) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_SEND;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Message byte selected by the current transmit index.
  always_comb begin
    w_msg_byte = 8'h00;
    case (r_idx)
      4'd0:    w_msg_byte = f_hex(r_word[31:28]);
      4'd1:    w_msg_byte = f_hex(r_word[27:24]);
      4'd2:    w_msg_byte = f_hex(r_word[23:20]);
      4'd3:    w_msg_byte = f_hex(r_word[19:16]);
      4'd4:    w_msg_byte = f_hex(r_word[15:12]);
      4'd5:    w_msg_byte = f_hex(r_word[11:8]);
      4'd6:    w_msg_byte = f_hex(r_word[7:4]);
      4'd7:    w_msg_byte = f_hex(r_word[3:0]);
`ifdef MESSAGE_PRINTER_POPCOUNT_EN
      4'd8:    w_msg_byte = 8'h20;
      4'd9:    w_msg_byte = f_hex({2'b00, r_pop[5:4]});
      4'd10:   w_msg_byte = f_hex(r_pop[3:0]);
      4'd11:   w_msg_byte = 8'h0D;
      4'd12:   w_msg_byte = 8'h0A;
`else
      4'd8:    w_msg_byte = 8'h0D;
      4'd9:    w_msg_byte = 8'h0A;
`endif
      default: w_msg_byte = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Payload capture, message index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_word    <= 32'h0000_0000;
      r_idx     <= 4'd0;
      r_tx_data <= 8'h00;
      r_new_tx  <= 1'b0;
      r_led     <= 8'h00;
`ifdef MESSAGE_PRINTER_POPCOUNT_EN
      r_pop     <= 6'd0;
`endif
    end else begin
      r_new_tx  <= w_send;
      r_tx_data <= w_send ? w_msg_byte : 8'h00;
      if (w_clear) begin
        r_cnt <= 2'd0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_shift) begin
        r_word <= w_word_next;
      end
      if (w_capture) begin
`ifdef MESSAGE_PRINTER_POPCOUNT_EN
        r_pop <= w_pop_next;
        r_led <= {2'b00, w_pop_next};
`else
        r_led <= w_word_next[31:24];
`endif
      end
      if (w_capture) begin
        r_idx <= 4'd0;
      end else if (w_send) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign tx_data     = r_tx_data;
  assign new_tx_data = r_new_tx;
  assign ledout      = r_led;

endmodule

// File: tb/tb_message_printer_ctrl.sv
// Scoreboard bench for message_printer_ctrl; expected TX bytes are queued by stimulus
// and popped by an independent monitor on every transmit strobe.
module tb_message_printer_ctrl;

`ifdef MESSAGE_PRINTER_POPCOUNT_EN
  localparam bit POP = 1'b1;
`else
  localparam bit POP = 1'b0;
`endif
  localparam int MSG_LEN = POP ? 13 : 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx_data = 1'b0;
  logic [7:0] ledout;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic prev_busy = 1'b0;
  logic prev_new = 1'b0;

  message_printer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .new_tx_data(new_tx_data),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .new_rx_data(new_rx_data),
    .ledout     (ledout)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_msg(input string hex8, input string pop2);
    for (int i = 0; i < 8; i++) exp_q.push_back(hex8[i]);
    if (POP) begin
      exp_q.push_back(8'h20);
      exp_q.push_back(pop2[0]);
      exp_q.push_back(pop2[1]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Called at posedge+1; returns at (capture edge of last byte)+1.
  task automatic send_seq(input logic [39:0] bytes, input int n, input bit burst);
    for (int i = 0; i < n; i++) begin
      if (!burst && i > 0) begin
        new_rx_data = 1'b0;
        @(posedge clk); #1;
      end
      rx_data = bytes[39-8*i -: 8];
      new_rx_data = 1'b1;
      @(posedge clk); #1;
    end
    new_rx_data = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("msg_complete_remaining", 8'(exp_q.size()), 8'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every strobe against the scoreboard queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (new_tx_data) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_strobe: got %02h expected no strobe at %0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_err++;
            $display("FAIL tx_byte: got %02h expected %02h at %0t", tx_data, e, $time);
          end
        end
        chk("strobe_while_busy", {7'd0, prev_busy}, 8'd0);
        chk("strobe_width", {7'd0, prev_new}, 8'd0);
      end else begin
        chk("idle_tx_data", tx_data, 8'h00);
      end
      prev_busy = tx_busy;
      prev_new  = new_tx_data;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_new_tx", {7'd0, new_tx_data}, 8'd0);
    chk("reset_led", ledout, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Spaced payload, strict strobe cadence.
    push_msg("B1000000", "04");
    send_seq({8'h68, 8'hB1, 8'h00, 8'h00, 8'h00}, 5, 1'b0);
    chk("led_b1", ledout, POP ? 8'h04 : 8'hB1);
    for (int j = 0; j < 2*MSG_LEN + 4; j++) begin
      @(posedge clk); #1;
      chk("strobe_cadence", {7'd0, new_tx_data}, {7'd0, (j < 2*MSG_LEN) && (j % 2 == 0)});
    end
    wait_done();

    // Back-to-back payload; an 'h' injected mid-message must be dropped.
    push_msg("01FFFFFF", "19");
    send_seq({8'h68, 8'h01, 8'hFF, 8'hFF, 8'hFF}, 5, 1'b1);
    chk("led_01ff", ledout, POP ? 8'h19 : 8'h01);
    repeat (3) @(posedge clk);
    #1;
    send_seq({8'h68, 32'h0}, 1, 1'b0);
    wait_done();

    // No 'h' in IDLE: nothing transmitted, LEDs untouched.
    send_seq({8'h41, 8'hB1, 8'h00, 8'h00, 8'h00}, 5, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("led_unchanged", ledout, POP ? 8'h19 : 8'h01);

    // 'h' inside payload is data; tx_busy stalls mid-message.
    push_msg("68000001", "04");
    send_seq({8'h68, 8'h68, 8'h00, 8'h00, 8'h01}, 5, 1'b1);
    chk("led_68", ledout, POP ? 8'h04 : 8'h68);
    repeat (8) @(posedge clk);
    #1;
    tx_busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("busy_no_strobe", {7'd0, new_tx_data}, 8'd0);
    end
    tx_busy = 1'b0;
    wait_done();

    // Reset aborts a partial payload.
    send_seq({8'h68, 8'hAA, 8'hBB, 16'h0}, 3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_new_tx", {7'd0, new_tx_data}, 8'd0);
    chk("rst_led", ledout, 8'h00);
    push_msg("FFFFFFFF", "20");
    send_seq({8'h68, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 5, 1'b0);
    chk("led_ff", ledout, POP ? 8'h20 : 8'hFF);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
